// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word holding buffer feeding a bit-strobed
// downstream consumer; back-to-back words stream without gaps when hold is pre-filled.
module bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             enable,
    output logic             x,
    output logic             x_valid,
    output logic             word_done
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic last_bit;
    logic load;
    logic accept;
    logic advance;

    assign last_bit = (state_q == SHIFT) && enable && (cnt_q == LAST_CNT);
    assign advance  = (state_q == SHIFT) && enable && (cnt_q != LAST_CNT);
    assign load     = hold_full_q && ((state_q == IDLE) || last_bit);
    assign accept   = din_valid && !hold_full_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = SHIFT;
            SHIFT:   if (last_bit && !load) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; the serial bit is taken from whichever end the shifter drains from
    always_comb begin
        x_valid   = (state_q == SHIFT);
        x         = 1'b0;
        if (x_valid) begin
            x = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
        end
        word_done = x_valid && enable && (cnt_q == LAST_CNT);
        din_ready = !hold_full_q;
    end

    // Holding register, shifter and bit counter next-state
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        if (accept) begin
            hold_d      = din;
            hold_full_d = 1'b1;
        end else if (load) begin
            hold_full_d = 1'b0;
        end
        if (load) begin
            shreg_d = hold_q;
            cnt_d   = '0;
        end else if (advance) begin
            shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CNT_W'(1);
        end else if (last_bit) begin
            shreg_d = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            cnt_q       <= '0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first and LSB-first instances share stimulus and are
// scored against a word-queue model of the expected serial stream.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       enable;
    logic       rdy_m, x_m, xv_m, wd_m;
    logic       rdy_l, x_l, xv_l, wd_l;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] wq_m[$];
    logic [7:0] wq_l[$];
    int         pos_m = 0;
    int         pos_l = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_m),
        .enable(enable), .x(x_m), .x_valid(xv_m), .word_done(wd_m)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_l),
        .enable(enable), .x(x_l), .x_valid(xv_l), .word_done(wd_l)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Model: each accepted word contributes 8 bits in shift order; one bit leaves per strobe.
    task automatic sb(input bit lsb, input logic rdy, input logic xv, input logic xo, input logic wd);
        logic [7:0] w;
        int         p;
        bit         empty;
        string      nm;
        nm    = lsb ? "l" : "m";
        empty = lsb ? (wq_l.size() == 0) : (wq_m.size() == 0);
        p     = lsb ? pos_l : pos_m;
        w     = '0;
        if (!empty) w = lsb ? wq_l[0] : wq_m[0];
        if (xv) begin
            if (empty) begin
                check_eq({nm, "_sb_underflow"}, 32'd1, 32'd0);
            end else begin
                check_eq({nm, "_x"}, 32'(xo), 32'(lsb ? w[p] : w[7-p]));
                check_eq({nm, "_word_done"}, 32'(wd), 32'(enable && (p == 7)));
                if (enable) begin
                    p++;
                    if (p == 8) begin
                        p = 0;
                        if (lsb) void'(wq_l.pop_front());
                        else     void'(wq_m.pop_front());
                    end
                end
            end
        end else begin
            check_eq({nm, "_x_idle"}, 32'(xo), 32'd0);
            check_eq({nm, "_wd_idle"}, 32'(wd), 32'd0);
        end
        if (lsb) pos_l = p;
        else     pos_m = p;
        if (din_valid && rdy) begin
            if (lsb) wq_l.push_back(din);
            else     wq_m.push_back(din);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic v, input logic e);
        din       = d;
        din_valid = v;
        enable    = e;
        #1;
        if (rst) begin
            sb(1'b0, rdy_m, xv_m, x_m, wd_m);
            sb(1'b1, rdy_l, xv_l, x_l, wd_l);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_flush();
        wq_m.delete();
        wq_l.delete();
        pos_m = 0;
        pos_l = 0;
    endtask

    // One word from idle with enable held: exact cycle-by-cycle expectations for both orders.
    task automatic single_word(input logic [7:0] w);
        drive(w, 1'b1, 1'b1);
        check_eq("sw_ready_pre", 32'(rdy_m), 32'd1);
        check_eq("sw_xv_pre", 32'(xv_m), 32'd0);
        tick();
        drive(8'h00, 1'b0, 1'b1);
        check_eq("sw_ready_held", 32'(rdy_m), 32'd0);
        check_eq("sw_xv_held", 32'(xv_m), 32'd0);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(8'h00, 1'b0, 1'b1);
            check_eq("sw_xv_m", 32'(xv_m), 32'd1);
            check_eq("sw_xv_l", 32'(xv_l), 32'd1);
            check_eq("sw_x_m", 32'(x_m), 32'(w[7-i]));
            check_eq("sw_x_l", 32'(x_l), 32'(w[i]));
            check_eq("sw_wd_m", 32'(wd_m), 32'(i == 7));
            check_eq("sw_ready", 32'(rdy_m), 32'd1);
            tick();
        end
        drive(8'h00, 1'b0, 1'b1);
        check_eq("sw_xv_post_m", 32'(xv_m), 32'd0);
        check_eq("sw_xv_post_l", 32'(xv_l), 32'd0);
        tick();
    endtask

    initial begin
        logic [7:0] wa;
        logic [7:0] wb;
        logic       e;
        int         guard;
        wa = 8'hA5;
        wb = 8'h3C;
        rst = 1'b0;
        din = '0;
        din_valid = 1'b0;
        enable = 1'b0;
        #1;
        check_eq("rst_x", 32'(x_m), 32'd0);
        check_eq("rst_xv", 32'(xv_m), 32'd0);
        check_eq("rst_ready", 32'(rdy_m), 32'd1);
        check_eq("rst_wd", 32'(wd_m), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        single_word(8'hA5);
        single_word(8'h01);

        // Back-to-back words: second word waits in hold, stream stays gapless
        drive(wa, 1'b1, 1'b1);
        check_eq("b2b_ready0", 32'(rdy_m), 32'd1);
        tick();
        drive(wb, 1'b1, 1'b1);
        check_eq("b2b_ready1", 32'(rdy_m), 32'd0);
        tick();
        for (int k = 0; k < 16; k++) begin
            drive(wb, 1'b1 && (k == 0), 1'b1);
            check_eq("b2b_xv", 32'(xv_m), 32'd1);
            check_eq("b2b_x", 32'(x_m), 32'(k < 8 ? wa[7-(k%8)] : wb[7-(k%8)]));
            check_eq("b2b_wd", 32'(wd_m), 32'((k % 8) == 7));
            check_eq("b2b_ready", 32'(rdy_m), 32'(!(k >= 1 && k <= 7)));
            tick();
        end
        drive(8'h00, 1'b0, 1'b1);
        check_eq("b2b_xv_end", 32'(xv_m), 32'd0);
        tick();

        // Enable toggling: each bit held two cycles, word_done only on strobe cycles
        drive(wa, 1'b1, 1'b1);
        tick();
        drive(8'h00, 1'b0, 1'b1);
        tick();
        for (int k = 0; k < 16; k++) begin
            e = 1'(k % 2);
            drive(8'h00, 1'b0, e);
            check_eq("tog_xv", 32'(xv_m), 32'd1);
            check_eq("tog_x", 32'(x_m), 32'(wa[7-(k/2)]));
            check_eq("tog_wd", 32'(wd_m), 32'(k == 15));
            tick();
        end
        drive(8'h00, 1'b0, 1'b1);
        check_eq("tog_xv_end", 32'(xv_m), 32'd0);
        tick();

        // Reset mid-word with a word waiting in hold
        drive(8'hFF, 1'b1, 1'b1);
        tick();
        drive(8'h00, 1'b1, 1'b1);
        tick();
        drive(8'h00, 1'b1, 1'b1);
        tick();
        drive(8'h00, 1'b0, 1'b1);
        tick();
        drive(8'h00, 1'b0, 1'b1);
        check_eq("pre_rst_ready", 32'(rdy_m), 32'd0);
        check_eq("pre_rst_x", 32'(x_m), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_x", 32'(x_m), 32'd0);
        check_eq("arst_xv", 32'(xv_m), 32'd0);
        check_eq("arst_ready", 32'(rdy_m), 32'd1);
        check_eq("arst_wd", 32'(wd_m), 32'd0);
        model_flush();
        din_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        single_word(8'h81);

        // Random traffic: din changes freely while not ready; model catches loss or duplication
        for (int c = 0; c < 1500; c++) begin
            drive(8'($urandom), 1'(($urandom % 4) != 0), 1'(($urandom % 3) != 0));
            tick();
        end
        guard = 0;
        while ((xv_m || xv_l || wq_m.size() != 0 || wq_l.size() != 0) && guard < 40) begin
            drive(8'h00, 1'b0, 1'b1);
            tick();
            guard++;
        end
        drive(8'h00, 1'b0, 1'b1);
        check_eq("drain_guard", 32'(guard < 40), 32'd1);
        check_eq("drain_q_m", 32'(wq_m.size()), 32'd0);
        check_eq("drain_q_l", 32'(wq_l.size()), 32'd0);
        check_eq("drain_xv", 32'(xv_m), 32'd0);
        check_eq("drain_ready", 32'(rdy_m), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
